// File: rtl/ltl_report_collector_if.sv
// rtl/ltl_report_collector_if.sv - record stream from the report collector to the aggregation logic
interface ltl_report_collector_if #(
   parameter int DATA_WIDTH = 20
);
   logic                  rec_valid;
   logic                  rec_ready;
   logic [DATA_WIDTH-1:0] rec_data;

   modport master (output rec_valid, output rec_data, input rec_ready);
   modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - timestamps LTL monitor reports and buffers them for draining
module ltl_report_collector #(
   parameter int NUM_REPORTS = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int TS_WIDTH    = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic [NUM_REPORTS-1:0]        report_in,
   ltl_report_collector_if.master        rec,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    drop_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REC_W = TS_WIDTH + NUM_REPORTS;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2
   } state_t;

   state_t               state;
   logic [TS_WIDTH-1:0]  ts;
   logic [REC_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     rd_ptr_nxt;
   logic                 push_req;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;
   logic [CNT_W-1:0]     count_after_pop;
   logic [CNT_W-1:0]     count_nxt;
   logic [REC_W-1:0]     push_data;
   logic [REC_W-1:0]     head_nxt;

   // Push/pop decisions and the record that will sit at the head after this edge
   always_comb begin
      push_req        = run & (|report_in);
      push_data       = {ts, report_in};
      pop             = rec.rec_valid & rec.rec_ready;
      push_ok         = push_req & ((state != FULL) | pop);
      drop            = push_req & ~push_ok;
      count_after_pop = fifo_count - CNT_W'(pop);
      count_nxt       = count_after_pop + CNT_W'(push_ok);
      rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
      // A record entering an otherwise-empty buffer is not in memory yet, so bypass it
      head_nxt        = (count_after_pop == '0) ? push_data : mem[rd_ptr_nxt];
   end

   // Record storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Occupancy FSM with registered head presentation on the record stream
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         fifo_count    <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rec.rec_valid <= 1'b0;
         rec.rec_data  <= '0;
      end else begin
         fifo_count    <= count_nxt;
         wr_ptr        <= wr_ptr + PTR_W'(push_ok);
         rd_ptr        <= rd_ptr_nxt;
         rec.rec_valid <= (count_nxt != '0);
         rec.rec_data  <= (count_nxt != '0) ? head_nxt : '0;
         case (state)
            IDLE: begin
               if (push_ok) begin
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (count_nxt == FULL_CNT) begin
                  state <= FULL;
               end else if (count_nxt == '0) begin
                  state <= IDLE;
               end
            end
            FULL: begin
               if (pop && !push_ok) begin
                  state <= ACTIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Run-cycle timestamp; wraps silently
   always_ff @(posedge clk) begin
      if (!reset) begin
         ts <= '0;
      end else if (run) begin
         ts <= ts + 1'b1;
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end
endmodule
